// File: rtl/ro_pkg.sv
// Shared types for the ring-oscillator measurement sequencer.
// No logic: state encoding, counter width and a window helper.
// No flow control.
package ro_pkg;
    localparam int RO_CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ARM,
        ST_RUN,
        ST_STOP,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } ro_state_e;

    // A zero-length window still runs the oscillator for one cycle.
    function automatic logic [RO_CNT_W-1:0] eff_window(input logic [RO_CNT_W-1:0] w);
        return (w == '0) ? RO_CNT_W'(1) : w;
    endfunction
endpackage

// File: rtl/ro_cycle_timer.sv
// Loadable down-counter with zero flag, shared by the CLR, RUN and SETTLE intervals.
// Latency: load takes effect next cycle; zero reflects the registered count.
// No backpressure: counts down every cycle until it reaches zero, then holds.
module ro_cycle_timer
    import ro_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [RO_CNT_W-1:0] load_val,
    output logic                zero
);
    logic [RO_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - RO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/ro_measure_ctrl.sv
// Sweeps NUM_RO ring oscillators: clear, run for a window, settle, capture count.
// Latency per RO from entering CLR to result_valid: CLR_CYCLES+1+W+1+SETTLE+1 cycles.
// No backpressure: results are one-cycle pulses; start is ignored while busy.
module ro_measure_ctrl
    import ro_pkg::*;
#(
    parameter int NUM_RO     = 8,
    parameter int SEL_W      = 3,
    parameter int CLR_CYCLES = 4,
    parameter int SETTLE     = 8
) (
    input  logic                CLK,
    input  logic                resetn,
    input  logic                start,
    input  logic [RO_CNT_W-1:0] window_len,
    input  logic                abort,
    output logic                ro_enable,
    output logic                ro_reset,
    output logic [SEL_W-1:0]    ro_sel,
    input  logic [RO_CNT_W-1:0] count_in,
    output logic [RO_CNT_W-1:0] result,
    output logic [SEL_W-1:0]    result_idx,
    output logic                result_valid,
    output logic                busy,
    output logic                done
);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_RO - 1);

    ro_state_e           state_q, state_d;
    logic [RO_CNT_W-1:0] win_q, win_d;
    logic [SEL_W-1:0]    ro_sel_q, ro_sel_d;
    logic [SEL_W-1:0]    result_idx_q, result_idx_d;
    logic [RO_CNT_W-1:0] result_q, result_d;
    logic                ro_enable_q, ro_enable_d;
    logic                ro_reset_q, ro_reset_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tmr_load;
    logic [RO_CNT_W-1:0] tmr_val;
    logic                tmr_zero;
    logic                finish;

    ro_cycle_timer u_timer (
        .clk      (CLK),
        .rst_n    (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d        = state_q;
        win_d          = win_q;
        ro_sel_d       = ro_sel_q;
        result_idx_d   = result_idx_q;
        result_d       = result_q;
        ro_enable_d    = ro_enable_q;
        ro_reset_d     = ro_reset_q;
        result_valid_d = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        finish         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_CLR;
                    busy_d      = 1'b1;
                    ro_sel_d    = '0;
                    win_d       = eff_window(window_len);
                    ro_reset_d  = 1'b1;
                    ro_enable_d = 1'b0;
                    tmr_load    = 1'b1;
                    tmr_val     = RO_CNT_W'(CLR_CYCLES - 1);
                end
            end
            ST_CLR: begin
                if (abort) begin
                    finish = 1'b1;
                end else if (tmr_zero) begin
                    state_d    = ST_ARM;
                    ro_reset_d = 1'b0;
                end
            end
            ST_ARM: begin
                // Counter clear is released a full cycle before the RO starts.
                if (abort) begin
                    finish = 1'b1;
                end else begin
                    state_d     = ST_RUN;
                    ro_enable_d = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = win_q - RO_CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    finish = 1'b1;
                end else if (tmr_zero) begin
                    state_d     = ST_STOP;
                    ro_enable_d = 1'b0;
                end
            end
            ST_STOP: begin
                state_d  = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = RO_CNT_W'(SETTLE - 1);
            end
            ST_SETTLE: begin
                if (abort) begin
                    finish = 1'b1;
                end else if (tmr_zero) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                result_d       = count_in;
                result_idx_d   = ro_sel_q;
                result_valid_d = 1'b1;
                if (abort || (ro_sel_q == LAST_SEL)) begin
                    finish = 1'b1;
                end else begin
                    state_d    = ST_CLR;
                    ro_sel_d   = ro_sel_q + SEL_W'(1);
                    ro_reset_d = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = RO_CNT_W'(CLR_CYCLES - 1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d     = ST_DONE;
            ro_enable_d = 1'b0;
            ro_reset_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            win_q          <= '0;
            ro_sel_q       <= '0;
            result_idx_q   <= '0;
            result_q       <= '0;
            ro_enable_q    <= 1'b0;
            ro_reset_q     <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            ro_sel_q       <= ro_sel_d;
            result_idx_q   <= result_idx_d;
            result_q       <= result_d;
            ro_enable_q    <= ro_enable_d;
            ro_reset_q     <= ro_reset_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign ro_enable    = ro_enable_q;
    assign ro_reset     = ro_reset_q;
    assign ro_sel       = ro_sel_q;
    assign result       = result_q;
    assign result_idx   = result_idx_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Bench for ro_measure_ctrl with a 4-RO sweep and a counter model of 3 counts per enabled cycle.
module tb_ro_measure_ctrl;
    localparam int NUM_RO = 4;
    localparam int SEL_W  = 2;
    localparam int CLR_C  = 4;
    localparam int SET_C  = 8;
    localparam int BUDGET = 5000;

    logic             CLK = 1'b0;
    logic             resetn;
    logic             start;
    logic [31:0]      window_len;
    logic             abort;
    logic             ro_enable;
    logic             ro_reset;
    logic [SEL_W-1:0] ro_sel;
    logic [31:0]      count_in;
    logic [31:0]      result;
    logic [SEL_W-1:0] result_idx;
    logic             result_valid;
    logic             busy;
    logic             done;

    always #5 CLK = ~CLK;

    ro_measure_ctrl #(
        .NUM_RO     (NUM_RO),
        .SEL_W      (SEL_W),
        .CLR_CYCLES (CLR_C),
        .SETTLE     (SET_C)
    ) dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .start        (start),
        .window_len   (window_len),
        .abort        (abort),
        .ro_enable    (ro_enable),
        .ro_reset     (ro_reset),
        .ro_sel       (ro_sel),
        .count_in     (count_in),
        .result       (result),
        .result_idx   (result_idx),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // RO counter model: cleared by ro_reset, +3 per enabled cycle.
    logic [31:0] ro_cnt = '0;
    always @(posedge CLK) begin
        if (ro_reset) ro_cnt <= '0;
        else if (ro_enable) ro_cnt <= ro_cnt + 32'd3;
    end
    assign count_in = ro_cnt;

    typedef struct {
        logic [SEL_W-1:0] idx;
        logic [31:0]      res;
    } exp_t;
    exp_t sb[$];

    int exp_w    = 1;
    bit skip_en  = 1'b0;
    int done_cnt = 0;

    task automatic push_ro(input int idx, input logic [31:0] w);
        exp_t e;
        e.idx = SEL_W'(idx);
        e.res = 32'd3 * ((w == 0) ? 32'd1 : w);
        sb.push_back(e);
    endtask

    // Monitor: interval timing, exclusivity and scoreboard, sampled on the falling edge.
    bit prev_rst, prev_en, gap_arm;
    int rst_run, gap, en_run, since_fall;
    always @(negedge CLK) begin
        if (!resetn) begin
            prev_rst = 0; prev_en = 0; gap_arm = 0;
            rst_run = 0; gap = 0; en_run = 0; since_fall = -1;
        end else begin
            check_eq("en_rst_exclusive", {31'd0, ro_enable & ro_reset}, 0);
            if (ro_reset) rst_run++;
            if (!ro_reset && prev_rst) begin
                check_eq("clr_len", rst_run, CLR_C);
                rst_run = 0; gap = 0; gap_arm = 1;
            end
            if (gap_arm && !ro_enable && !ro_reset) gap++;
            if (ro_enable && !prev_en) begin
                if (gap_arm) check_eq("arm_gap", gap, 1);
                gap_arm = 0; en_run = 0;
            end
            if (ro_enable) en_run++;
            if (!ro_enable && prev_en) begin
                if (!skip_en) check_eq("run_len", en_run, exp_w);
                en_run = 0; since_fall = 0;
            end else if (since_fall >= 0) begin
                since_fall++;
            end
            if (result_valid) begin
                check_eq("rv_after_fall", since_fall, SET_C + 2);
                since_fall = -1;
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("result_idx", {30'd0, result_idx}, {30'd0, e.idx});
                    check_eq("result", result, e.res);
                end
            end
            if (done) begin
                done_cnt++;
                check_eq("busy_at_done", {31'd0, busy}, 0);
            end
            prev_rst = ro_reset;
            prev_en  = ro_enable;
        end
    end

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < BUDGET) begin
            @(negedge CLK);
            n++;
        end
        check_eq("done_seen", done_cnt, prev + 1);
    endtask

    task automatic wait_sel_en(input int sel);
        int n = 0;
        while (!(int'(ro_sel) == sel && ro_enable) && n < BUDGET) begin
            @(negedge CLK);
            n++;
        end
        check_eq("reach_run", {31'd0, n < BUDGET}, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_en"},   {31'd0, ro_enable}, 0);
        check_eq({tag, "_rst"},  {31'd0, ro_reset}, 0);
        check_eq({tag, "_sel"},  {30'd0, ro_sel}, 0);
        check_eq({tag, "_res"},  result, 0);
        check_eq({tag, "_idx"},  {30'd0, result_idx}, 0);
        check_eq({tag, "_rv"},   {31'd0, result_valid}, 0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 0);
        check_eq({tag, "_done"}, {31'd0, done}, 0);
    endtask

    task automatic run_sweep(input logic [31:0] w);
        int d0;
        window_len = w;
        exp_w = (w == 0) ? 1 : int'(w);
        for (int i = 0; i < NUM_RO; i++) push_ro(i, w);
        d0 = done_cnt;
        pulse_start();
        check_eq("busy_after_start", {31'd0, busy}, 1);
        wait_done(d0);
        check_eq("sb_drained", sb.size(), 0);
        @(negedge CLK);
        check_eq("busy_after_done", {31'd0, busy}, 0);
    endtask

    initial begin
        int d0;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; window_len = '0;
        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        @(posedge CLK); #2 resetn = 1'b1;

        run_sweep(32'd100);
        run_sweep(32'd0);
        run_sweep(32'd10);

        // start together with abort in IDLE is ignored
        d0 = done_cnt;
        abort = 1'b1;
        pulse_start();
        repeat (3) @(negedge CLK);
        check_eq("abort_start_busy", {31'd0, busy}, 0);
        check_eq("abort_start_done", done_cnt, d0);
        abort = 1'b0;

        // abort during RUN of RO 2
        window_len = 32'd40; exp_w = 40;
        push_ro(0, 32'd40); push_ro(1, 32'd40);
        d0 = done_cnt;
        pulse_start();
        wait_sel_en(2);
        repeat (5) @(posedge CLK);
        #1 abort = 1'b1; skip_en = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("abort_en_low", {31'd0, ro_enable}, 0);
        wait_done(d0);
        #1 abort = 1'b0;
        repeat (SET_C + 4) @(negedge CLK);
        check_eq("abort_sb_drained", sb.size(), 0);
        check_eq("abort_busy", {31'd0, busy}, 0);
        skip_en = 1'b0;

        // start and window_len changes mid-sweep have no effect
        window_len = 32'd20; exp_w = 20;
        for (int i = 0; i < NUM_RO; i++) push_ro(i, 32'd20);
        d0 = done_cnt;
        pulse_start();
        wait_sel_en(1);
        #1 window_len = 32'd50;
        pulse_start();
        wait_done(d0);
        check_eq("midsweep_sb_drained", sb.size(), 0);
        check_eq("midsweep_one_done", done_cnt, d0 + 1);

        // reset in SETTLE of RO 1
        window_len = 32'd30; exp_w = 30;
        for (int i = 0; i < NUM_RO; i++) push_ro(i, 32'd30);
        pulse_start();
        wait_sel_en(1);
        while (ro_enable) @(negedge CLK);
        @(posedge CLK); #2 resetn = 1'b0;
        #1 check_outputs_zero("async_rst");
        sb.delete();
        repeat (2) @(posedge CLK);
        #2 resetn = 1'b1;
        run_sweep(32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
